// File: rtl/seq_det_pkg.sv
// rtl/seq_det_pkg.sv - shared constants and types for the programmable sequence detector
//
// Purpose : width helper, power-on pattern defaults and overlap-mode encoding
//           used by seq_detector_prog and its bench.
// Ports   : none (package).

package seq_det_pkg;

   // Width needed to hold a length value in the range 0..max_len inclusive.
   function automatic int len_w(input int max_len);
      return $clog2(max_len + 1);
   endfunction

   localparam int          DEF_MAX_LEN = 8;
   localparam int          DEF_LEN_W   = len_w(DEF_MAX_LEN);

   // Power-on pattern 11011 (first received bit is bit RST_LEN-1).
   localparam logic [31:0] DEF_RST_PAT = 32'b0001_1011;
   localparam int          DEF_RST_LEN = 5;

   typedef enum logic {
      OVL_OFF = 1'b0,
      OVL_ON  = 1'b1
   } ovl_mode_e;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with clear-over-increment priority
//
// Purpose : counts single-cycle increment requests, sticking at all-ones.
// Ports   : clk   - clock, rising edge
//           reset - asynchronous active-high reset, q -> 0
//           inc   - increment request
//           clr   - synchronous clear, wins over inc in the same cycle
//           q     - current count (W bits)

module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         inc,
   input  logic         clr,
   output logic [W-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (inc && (q != '1)) begin
         q <= q + W'(1);
      end
   end

endmodule

// File: rtl/seq_detector_prog.sv
// rtl/seq_detector_prog.sv - runtime-programmable Moore serial sequence detector
//
// Purpose : hunts for a loadable pattern (1..MAX_LEN bits) in a valid-qualified
//           serial stream, with overlapping or non-overlapping detection,
//           a registered one-cycle match pulse and a saturating match counter.
// Ports   : clk       - clock, rising edge
//           reset     - asynchronous active-high reset
//           in        - serial data bit
//           in_valid  - in is sampled only when high
//           overlap   - 1 = overlapping detection, 0 = non-overlapping
//           pat_load  - load pat_in/len_in this cycle (has priority over data)
//           pat_in    - new pattern, bit len-1 received first, bit 0 last
//           len_in    - new pattern length (0 -> 1, >MAX_LEN -> MAX_LEN)
//           y         - registered match pulse
//           match_cnt - saturating count of matches
//           clr_cnt   - synchronous clear of match_cnt
//           busy_fill - number of valid history bits currently held

module seq_detector_prog
   import seq_det_pkg::*;
#(
   parameter int                 MAX_LEN = 8,
   parameter int                 CNT_W   = 8,
   parameter logic [MAX_LEN-1:0] RST_PAT = MAX_LEN'(DEF_RST_PAT),
   parameter int                 RST_LEN = DEF_RST_LEN
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         in,
   input  logic                         in_valid,
   input  logic                         overlap,
   input  logic                         pat_load,
   input  logic [MAX_LEN-1:0]           pat_in,
   input  logic [len_w(MAX_LEN)-1:0]    len_in,
   output logic                         y,
   output logic [CNT_W-1:0]             match_cnt,
   input  logic                         clr_cnt,
   output logic [len_w(MAX_LEN)-1:0]    busy_fill
);

   localparam int LEN_W = len_w(MAX_LEN);

   logic [MAX_LEN-1:0] hist_q, hist_d, hist_shift;
   logic [MAX_LEN-1:0] pat_q, pat_d;
   logic [MAX_LEN-1:0] len_mask;
   logic [LEN_W-1:0]   len_q, len_d, len_clamped;
   logic [LEN_W-1:0]   fill_q, fill_d;
   logic [LEN_W:0]     fill_inc;
   logic               y_q, y_d;
   logic               accept, fill_ok, pat_ok, match;

   // ------------------------------------------------------------------
   // Datapath helpers
   // ------------------------------------------------------------------
   assign accept     = in_valid & ~pat_load;
   assign hist_shift = {hist_q[MAX_LEN-2:0], in};

   // One extra bit so fill+1 never wraps when fill already equals len.
   assign fill_inc   = {1'b0, fill_q} + (LEN_W+1)'(1);
   assign fill_ok    = (fill_inc >= {1'b0, len_q});

   // Only the low len bits of history and pattern take part in the compare.
   always_comb begin
      len_mask = '0;
      for (int i = 0; i < MAX_LEN; i++) begin
         len_mask[i] = (i < int'(len_q));
      end
   end

   assign pat_ok = (((hist_shift ^ pat_q) & len_mask) == '0);
   assign match  = accept & fill_ok & pat_ok;

   always_comb begin
      len_clamped = len_in;
      if (len_in == '0) begin
         len_clamped = LEN_W'(1);
      end else if (len_in > LEN_W'(MAX_LEN)) begin
         len_clamped = LEN_W'(MAX_LEN);
      end
   end

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hist_q <= '0;
         pat_q  <= RST_PAT;
         len_q  <= LEN_W'(RST_LEN);
         fill_q <= '0;
         y_q    <= 1'b0;
      end else begin
         hist_q <= hist_d;
         pat_q  <= pat_d;
         len_q  <= len_d;
         fill_q <= fill_d;
         y_q    <= y_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      hist_d = hist_q;
      pat_d  = pat_q;
      len_d  = len_q;
      fill_d = fill_q;
      y_d    = 1'b0;

      if (pat_load) begin
         // A new pattern invalidates everything collected so far.
         pat_d  = pat_in;
         len_d  = len_clamped;
         hist_d = '0;
         fill_d = '0;
      end else if (accept) begin
         hist_d = hist_shift;
         y_d    = match;
         if (match && (ovl_mode_e'(overlap) == OVL_OFF)) begin
            // Non-overlapping: the matched bits are consumed.
            fill_d = '0;
         end else if (fill_inc > {1'b0, len_q}) begin
            fill_d = len_q;
         end else begin
            fill_d = fill_inc[LEN_W-1:0];
         end
      end
   end

   // ------------------------------------------------------------------
   // Output logic (Moore: outputs depend only on registered state)
   // ------------------------------------------------------------------
   always_comb begin
      y         = y_q;
      busy_fill = fill_q;
   end

   // The count advances on the same edge that registers y, so match_cnt
   // already includes a match while its y pulse is high.
   sat_counter #(
      .W (CNT_W)
   ) u_match_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (match),
      .clr   (clr_cnt),
      .q     (match_cnt)
   );

endmodule

// File: tb/tb_seq_detector_prog.sv
// tb/tb_seq_detector_prog.sv - self-checking bench for seq_detector_prog

module tb_seq_detector_prog;
   import seq_det_pkg::*;

   localparam int MAX_LEN = 8;
   localparam int LEN_W   = len_w(MAX_LEN);

   logic               clk = 1'b0;
   logic               reset, in, in_valid, overlap, pat_load, clr_cnt;
   logic [MAX_LEN-1:0] pat_in;
   logic [LEN_W-1:0]   len_in;
   logic               y, y_c;
   logic [7:0]         match_cnt;
   logic [1:0]         cnt_c;
   logic [LEN_W-1:0]   busy_fill, fill_c;

   int checks  = 0;
   int errors  = 0;
   int exp_cnt = 0;

   typedef struct {
      string tag;
      logic  y;
      int    cnt;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap(overlap),
      .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .y(y),
      .match_cnt(match_cnt), .clr_cnt(clr_cnt), .busy_fill(busy_fill)
   );

   seq_detector_prog #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_c (
      .clk(clk), .reset(reset), .in(in), .in_valid(in_valid), .overlap(overlap),
      .pat_load(pat_load), .pat_in(pat_in), .len_in(len_in), .y(y_c),
      .match_cnt(cnt_c), .clr_cnt(clr_cnt), .busy_fill(fill_c)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_fill(input string tag, input int exp);
      chk({tag, "_fill"}, 32'(busy_fill), exp);
      chk({tag, "_fillc"}, 32'(fill_c), exp);
   endtask

   // One clock of stimulus; the expectation is queued when driven and
   // compared once the registered outputs have settled after the edge.
   task automatic step(input string tag, input logic b, input logic v,
                       input logic exp_y, input logic clr = 1'b0);
      exp_t e;
      in       = b;
      in_valid = v;
      clr_cnt  = clr;
      if (clr) exp_cnt = 0;
      else if (exp_y) exp_cnt++;
      e.tag = tag;
      e.y   = exp_y;
      e.cnt = exp_cnt;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      chk({e.tag, "_y"}, 32'(y), 32'(e.y));
      chk({e.tag, "_yc"}, 32'(y_c), 32'(e.y));
      chk({e.tag, "_cnt"}, 32'(match_cnt), e.cnt);
      chk({e.tag, "_cntc"}, 32'(cnt_c), (e.cnt > 3) ? 3 : e.cnt);
      in_valid = 1'b0;
      clr_cnt  = 1'b0;
   endtask

   // Feed n accepted bits, first bit is bits[n-1]; hits[i] marks the bits
   // (counted from the first, index 0) that complete a match.
   task automatic run(input string tag, input logic [31:0] bits, input int n,
                      input logic [31:0] hits);
      for (int i = 0; i < n; i++) begin
         step($sformatf("%s_b%0d", tag, i + 1), bits[n-1-i], 1'b1, hits[i]);
      end
   endtask

   task automatic do_reset(input string tag);
      reset   = 1'b1;
      exp_cnt = 0;
      sb.delete();
      #2;
      chk({tag, "_rst_y"}, 32'(y), 0);
      chk({tag, "_rst_cnt"}, 32'(match_cnt), 0);
      chk({tag, "_rst_cntc"}, 32'(cnt_c), 0);
      chk_fill({tag, "_rst"}, 0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   // Load with in_valid=1 on the same cycle: the data bit must be ignored.
   task automatic load(input string tag, input logic [MAX_LEN-1:0] p,
                       input logic [LEN_W-1:0] l);
      pat_load = 1'b1;
      pat_in   = p;
      len_in   = l;
      in       = 1'b1;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      chk({tag, "_y"}, 32'(y), 0);
      chk_fill(tag, 0);
      pat_load = 1'b0;
      in_valid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in = 1'b0; in_valid = 1'b0; overlap = 1'b1;
      pat_load = 1'b0; clr_cnt = 1'b0; pat_in = '0; len_in = '0;
      #3;
      do_reset("init");

      // Default pattern 11011, overlapping.
      overlap = 1'b1;
      run("ovl", 32'b1101_1011, 8, 32'b1001_0000);
      chk_fill("ovl_end", 5);

      // Same stream, non-overlapping.
      do_reset("r2");
      overlap = 1'b0;
      run("novl", 32'b1101_1011, 8, 32'b0001_0000);
      chk_fill("novl_end", 3);

      // Pattern 101, length 3.
      overlap = 1'b1;
      load("ld101a", 8'b0000_0101, 4'd3);
      run("p101o", 32'b10101, 5, 32'b10100);
      overlap = 1'b0;
      load("ld101b", 8'b0000_0101, 4'd3);
      run("p101n", 32'b10101, 5, 32'b00100);

      // Gaps in in_valid are transparent.
      do_reset("r3");
      overlap = 1'b1;
      step("g1", 1'b1, 1'b1, 1'b0);
      step("gi1", 1'b0, 1'b0, 1'b0);
      step("g2", 1'b1, 1'b1, 1'b0);
      step("g3", 1'b0, 1'b1, 1'b0);
      step("gi2", 1'b1, 1'b0, 1'b0);
      step("g4", 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) step($sformatf("gidle%0d", i), 1'b1, 1'b0, 1'b0);
      step("g5", 1'b1, 1'b1, 1'b1);
      step("gpost", 1'b0, 1'b0, 1'b0);

      // Five matches: 8-bit counter reaches 5, 2-bit counter saturates at 3.
      do_reset("r4");
      overlap = 1'b1;
      load("ldsat", 8'b0000_0101, 4'd3);
      run("sat", 32'b101_0101_0101, 11, 32'b101_0101_0100);
      // Clear in the same cycle as a match: clear wins, y still pulses.
      step("clr0", 1'b0, 1'b1, 1'b0);
      step("clrm", 1'b1, 1'b1, 1'b1, 1'b1);
      step("aft0", 1'b0, 1'b1, 1'b0);
      step("aft1", 1'b1, 1'b1, 1'b1);

      // Reset during a partial match leaves no stale history.
      do_reset("r5");
      overlap = 1'b1;
      run("pre", 32'b1101, 4, 32'b0);
      chk_fill("pre", 4);
      do_reset("mid");
      run("post", 32'b11011, 5, 32'b10000);

      // Reset reverts a loaded pattern to 11011.
      load("ld3", 8'b0000_0101, 4'd3);
      run("l3", 32'b101, 3, 32'b100);
      do_reset("r6");
      run("rev", 32'b11011, 5, 32'b10000);

      // len_in = 0 behaves as length 1.
      load("ld0", 8'b0000_0001, 4'd0);
      run("len0", 32'b101, 3, 32'b101);
      chk_fill("len0", 1);

      // len_in = 15 is clamped to MAX_LEN.
      load("ld15", 8'hA5, 4'd15);
      run("len15", 32'hA5, 8, 32'h80);
      chk_fill("len15", 8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
